// File: rtl/mc_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset datapath (PC, IR, ALU, DM, GPR).
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN adds a sticky 'illegal' output and a HALT trap state.
`timescale 1ns/1ps
module mc_ctrl #(
    parameter int unsigned FETCH_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pcwr,
    output logic       irwr,
    output logic [1:0] npc_sel,
    output logic       ExtOp,
    output logic       ALUSrc,
    output logic [2:0] ALUOp,
    output logic       dmwr,
    output logic       gprwr,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       write_30,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       instr_done
);

    localparam logic [2:0] WAIT_INIT = 3'(FETCH_WAIT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DCD, S_EXE, S_WB, S_MA, S_MR,
        S_MW, S_LWB, S_BR, S_JMP, S_HALT
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_addi;
    logic is_lw, is_sw, is_beq, is_j, is_jal;
    logic cls_exe, cls_mem, cls_jmp;

    always_comb begin
        is_r    = (op == 6'b000000);
        is_addu = is_r && (funct == 6'b100001);
        is_subu = is_r && (funct == 6'b100011);
        is_jr   = is_r && (funct == 6'b001000);
        is_ori  = (op == 6'b001101);
        is_lui  = (op == 6'b001111);
        is_addi = (op == 6'b001000);
        is_lw   = (op == 6'b100011);
        is_sw   = (op == 6'b101011);
        is_beq  = (op == 6'b000100);
        is_j    = (op == 6'b000010);
        is_jal  = (op == 6'b000011);
        cls_exe = is_addu || is_subu || is_ori || is_lui || is_addi;
        cls_mem = is_lw || is_sw;
        cls_jmp = is_j || is_jal || is_jr;
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            // Counter reloads every non-FETCH cycle so it is full on FETCH entry.
            if (state != S_FETCH)
                wait_cnt <= WAIT_INIT;
            else if (wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;

            case (state)
                S_IDLE:  state <= S_FETCH;
                S_FETCH: if (wait_cnt == 3'd0) state <= S_DCD;
                S_DCD: begin
                    if (cls_exe)      state <= S_EXE;
                    else if (cls_mem) state <= S_MA;
                    else if (is_beq)  state <= S_BR;
                    else if (cls_jmp) state <= S_JMP;
                    else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        state     <= S_HALT;
                        illegal_q <= 1'b1;
`else
                        state <= S_FETCH;
`endif
                    end
                end
                S_EXE:   state <= S_WB;
                S_MA:    state <= is_lw ? S_MR : S_MW;
                S_MR:    state <= S_LWB;
                S_WB, S_MW, S_LWB, S_BR, S_JMP: state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal = illegal_q & ~rst;
`endif

    logic       alu_src, alu_ext;
    logic [2:0] alu_op;

    always_comb begin
        alu_src = 1'b0;
        alu_ext = 1'b0;
        alu_op  = 3'b000;
        if (is_subu) begin
            alu_op = 3'b001;
        end else if (is_ori) begin
            alu_src = 1'b1;
            alu_op  = 3'b010;
        end else if (is_lui) begin
            alu_src = 1'b1;
            alu_op  = 3'b011;
        end else if (is_addi) begin
            alu_src = 1'b1;
            alu_ext = 1'b1;
        end
    end

    // Outputs are forced low during reset so no write can straddle the reset edge.
    always_comb begin
        pcwr       = 1'b0;
        irwr       = 1'b0;
        npc_sel    = 2'b00;
        ExtOp      = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = 3'b000;
        dmwr       = 1'b0;
        gprwr      = 1'b0;
        RegDst     = 2'b00;
        MemToReg   = 2'b00;
        write_30   = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    if (wait_cnt == 3'd0) begin
                        pcwr = 1'b1;
                        irwr = 1'b1;
                    end
                end
                S_EXE: begin
                    ALUSrc = alu_src;
                    ExtOp  = alu_ext;
                    ALUOp  = alu_op;
                end
                S_WB: begin
                    ALUSrc     = alu_src;
                    ExtOp      = alu_ext;
                    ALUOp      = alu_op;
                    gprwr      = 1'b1;
                    RegDst     = is_r ? 2'b01 : 2'b00;
                    write_30   = is_addi && overflow;
                    instr_done = 1'b1;
                end
                S_MA, S_MR: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                S_MW: begin
                    ALUSrc     = 1'b1;
                    ExtOp      = 1'b1;
                    dmwr       = 1'b1;
                    instr_done = 1'b1;
                end
                S_LWB: begin
                    gprwr      = 1'b1;
                    MemToReg   = 2'b01;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    ALUOp      = 3'b001;
                    ExtOp      = 1'b1;
                    npc_sel    = 2'b01;
                    pcwr       = zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pcwr       = 1'b1;
                    npc_sel    = is_jr ? 2'b11 : 2'b10;
                    instr_done = 1'b1;
                    if (is_jal) begin
                        gprwr    = 1'b1;
                        RegDst   = 2'b10;
                        MemToReg = 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: per-class state sequences, wait states, reset and illegal handling.
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2, zero, overflow;
    logic [5:0] op, funct, op2, funct2;

    logic       pcwr, irwr, ExtOp, ALUSrc, dmwr, gprwr, write_30, instr_done;
    logic [1:0] npc_sel, RegDst, MemToReg;
    logic [2:0] ALUOp;
    logic       d2_pcwr, d2_irwr, d2_ExtOp, d2_ALUSrc, d2_dmwr, d2_gprwr, d2_write_30, d2_instr_done;
    logic [1:0] d2_npc_sel, d2_RegDst, d2_MemToReg;
    logic [2:0] d2_ALUOp;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal, d2_illegal;
`endif

    mc_ctrl #(.FETCH_WAIT(0)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
        .pcwr(pcwr), .irwr(irwr), .npc_sel(npc_sel), .ExtOp(ExtOp), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .dmwr(dmwr), .gprwr(gprwr), .RegDst(RegDst), .MemToReg(MemToReg),
        .write_30(write_30),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .instr_done(instr_done)
    );

    mc_ctrl #(.FETCH_WAIT(2)) dut2 (
        .clk(clk), .rst(rst2), .op(op2), .funct(funct2), .zero(zero), .overflow(overflow),
        .pcwr(d2_pcwr), .irwr(d2_irwr), .npc_sel(d2_npc_sel), .ExtOp(d2_ExtOp), .ALUSrc(d2_ALUSrc),
        .ALUOp(d2_ALUOp), .dmwr(d2_dmwr), .gprwr(d2_gprwr), .RegDst(d2_RegDst), .MemToReg(d2_MemToReg),
        .write_30(d2_write_30),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        .illegal(d2_illegal),
`endif
        .instr_done(d2_instr_done)
    );

    wire [16:0] obs  = {pcwr, irwr, npc_sel, ExtOp, ALUSrc, ALUOp, dmwr, gprwr,
                        RegDst, MemToReg, write_30, instr_done};
    wire [16:0] obs2 = {d2_pcwr, d2_irwr, d2_npc_sel, d2_ExtOp, d2_ALUSrc, d2_ALUOp, d2_dmwr,
                        d2_gprwr, d2_RegDst, d2_MemToReg, d2_write_30, d2_instr_done};

    int tests = 0;
    int fails = 0;

    // Field order: pcwr irwr npc_sel ExtOp ALUSrc ALUOp dmwr gprwr RegDst MemToReg write_30 instr_done
    function automatic logic [16:0] ov(input int p, input int i, input int n, input int e,
                                       input int s, input int a, input int dm, input int g,
                                       input int rd, input int m2r, input int w, input int d);
        return {1'(p), 1'(i), 2'(n), 1'(e), 1'(s), 3'(a), 1'(dm), 1'(g), 2'(rd), 2'(m2r), 1'(w), 1'(d)};
    endfunction

    task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; zero = 1'b0; overflow = 1'b0;
        op = 6'b000000; funct = 6'b100001; op2 = 6'b000000; funct2 = 6'b100001;

        tick();                              chk("reset_outputs", obs, 17'd0);
        chk("reset_outputs_fw2", obs2, 17'd0);
        rst = 1'b0;                          chk("idle", obs, 17'd0);
        tick();                              chk("addu_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));
        tick();                              chk("addu_dcd", obs, 17'd0);
        tick();                              chk("addu_exe", obs, 17'd0);
        tick();                              chk("addu_wb", obs, ov(0,0,0,0,0,0,0,1,1,0,0,1));
        tick();                              chk("addu_next_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));

        funct = 6'b100011;
        tick(); tick();                      chk("subu_exe", obs, ov(0,0,0,0,0,1,0,0,0,0,0,0));
        tick();                              chk("subu_wb", obs, ov(0,0,0,0,0,1,0,1,1,0,0,1));
        tick();

        op = 6'b001000; overflow = 1'b1;
        tick(); tick();                      chk("addi_exe", obs, ov(0,0,0,1,1,0,0,0,0,0,0,0));
        tick();                              chk("addi_wb_ovf", obs, ov(0,0,0,1,1,0,0,1,0,0,1,1));
        tick();
        overflow = 1'b0;
        tick(); tick(); tick();              chk("addi_wb_noovf", obs, ov(0,0,0,1,1,0,0,1,0,0,0,1));
        tick();

        op = 6'b001101;
        tick(); tick();                      chk("ori_exe", obs, ov(0,0,0,0,1,2,0,0,0,0,0,0));
        tick();                              chk("ori_wb", obs, ov(0,0,0,0,1,2,0,1,0,0,0,1));
        tick();

        op = 6'b001111;
        tick(); tick(); tick();              chk("lui_wb", obs, ov(0,0,0,0,1,3,0,1,0,0,0,1));
        tick();

        op = 6'b100011;
        tick(); tick();                      chk("lw_ma", obs, ov(0,0,0,1,1,0,0,0,0,0,0,0));
        tick();                              chk("lw_mr_nowrite", {14'd0, gprwr, dmwr, instr_done}, 17'd0);
        tick();                              chk("lw_lwb", obs, ov(0,0,0,0,0,0,0,1,0,1,0,1));
        tick();                              chk("lw_next_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));

        op = 6'b101011;
        tick(); tick();                      chk("sw_ma", obs, ov(0,0,0,1,1,0,0,0,0,0,0,0));
        tick();                              chk("sw_mw", obs, ov(0,0,0,1,1,0,1,0,0,0,0,1));
        tick();                              chk("sw_next_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));

        op = 6'b000100; zero = 1'b1;
        tick(); tick();                      chk("beq_taken", obs, ov(1,0,1,1,0,1,0,0,0,0,0,1));
        tick();                              chk("beq_taken_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));
        zero = 1'b0;
        tick(); tick();                      chk("beq_not_taken", obs, ov(0,0,1,1,0,1,0,0,0,0,0,1));
        tick();                              chk("beq_nt_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));

        op = 6'b000011;
        tick(); tick();                      chk("jal_jmp", obs, ov(1,0,2,0,0,0,0,1,2,2,0,1));
        tick();
        op = 6'b000000; funct = 6'b001000;
        tick(); tick();                      chk("jr_jmp", obs, ov(1,0,3,0,0,0,0,0,0,0,0,1));
        tick();
        op = 6'b000010;
        tick(); tick();                      chk("j_jmp", obs, ov(1,0,2,0,0,0,0,0,0,0,0,1));
        tick();

        op = 6'b111111;
        tick();                              chk("undef_dcd", obs, 17'd0);
        tick();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("undef_halt", obs, 17'd0);
        chk("illegal_set", {16'd0, illegal}, 17'd1);
        op = 6'b000000; funct = 6'b100001;
        tick();                              chk("halt_hold", obs, 17'd0);
        chk("illegal_sticky", {16'd0, illegal}, 17'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;                          chk("illegal_cleared", {16'd0, illegal}, 17'd0);
        tick();                              chk("post_halt_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));
`else
        chk("undef_nop_fetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));
        op = 6'b000000; funct = 6'b100001;
`endif

        tick(); tick();                      chk("rst_exe_before", obs, 17'd0);
        rst = 1'b1;                          chk("rst_in_exe", obs, 17'd0);
        tick();                              chk("rst_idle_no_gprwr", obs, 17'd0);
        rst = 1'b0;                          chk("rst_idle_released", obs, 17'd0);
        tick();                              chk("rst_refetch", obs, ov(1,1,0,0,0,0,0,0,0,0,0,0));

        rst2 = 1'b0;
        tick();                              chk("fw2_fetch_wait1", obs2, 17'd0);
        tick();                              chk("fw2_fetch_wait2", obs2, 17'd0);
        tick();                              chk("fw2_fetch_go", obs2, ov(1,1,0,0,0,0,0,0,0,0,0,0));
        tick();                              chk("fw2_dcd", obs2, 17'd0);
        tick(); tick();                      chk("fw2_wb", obs2, ov(0,0,0,0,0,0,0,1,1,0,0,1));
        tick();                              chk("fw2_refetch_wait", obs2, 17'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS-subset processor.
- Sequences PC, instruction register, ALU, data memory and the GPR file per instruction class.
- Drives the GPR write controls: gprwr, RegDst, MemToReg, write_30.
- Decodes from the stable IR fields op/funct plus ALU status (zero, overflow).

Parameters:
- FETCH_WAIT, 0, extra instruction-memory wait cycles held in FETCH before IR/PC update (0..7).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (valid in BR)
- overflow  in  1  ALU signed overflow (valid in WB for addi)
- pcwr  out  1  PC write enable
- irwr  out  1  IR write enable
- npc_sel  out  2  00 pc+4, 01 branch target, 10 j/jal target, 11 rs (jr)
- ExtOp  out  1  0 zero-extend, 1 sign-extend imm16
- ALUSrc  out  1  0 rt data, 1 extended imm
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16)
- dmwr  out  1  data-memory write enable
- gprwr  out  1  GPR write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemToReg  out  2  00 ALU reg, 01 DM reg, 10 pc_p4
- write_30  out  1  force write of 1 to $30 (addi overflow)
- instr_done  out  1  one-cycle pulse in final state of each instruction

Behaviour:
- Clock and reset: reset is synchronous and active-high on clk/rst; every output is 0 while rst is high.
- Reset state IDLE, all outputs 0. IDLE -> FETCH unconditionally next cycle.
- Outputs are combinational from state, op and funct. IR is stable after FETCH.
- FETCH:
  - wait counter loads FETCH_WAIT on entry and decrements each cycle.
  - While counter != 0: all outputs 0.
  - At counter == 0: pcwr=1, irwr=1, npc_sel=00, then -> DCD.
- DCD: no write enables. Next state by class:
  - R (op=000000; addu funct=100001, subu 100011) / ori 001101 / lui 001111 / addi 001000 -> EXE
  - lw 100011 / sw 101011 -> MA
  - beq 000100 -> BR
  - j 000010 / jal 000011 / jr (R, funct 001000) -> JMP
- EXE -> WB. ALU controls in EXE and held in WB:
  - addu: ALUSrc=0, ALUOp=000
  - subu: ALUOp=001
  - ori: ALUSrc=1, ExtOp=0, ALUOp=010
  - lui: ALUSrc=1, ALUOp=011
  - addi: ALUSrc=1, ExtOp=1, ALUOp=000
- WB: gprwr=1, MemToReg=00, instr_done=1, -> FETCH.
  - RegDst=01 for R-type, 00 otherwise.
  - addi with overflow=1: write_30=1, RegDst=00 (GPR redirects to $30 value 1). With overflow=0: write_30=0, normal rt write.
  - write_30 is never 1 outside WB-addi.
- MA: ALUSrc=1, ExtOp=1, ALUOp=000.
  - lw -> MR; sw -> MW.
- MW: dmwr=1, ALU controls held, instr_done=1, -> FETCH.
- MR -> LWB.
- LWB: gprwr=1, RegDst=00, MemToReg=01, instr_done=1, -> FETCH.
- BR: ALUSrc=0, ALUOp=001, ExtOp=1, npc_sel=01, pcwr=zero, instr_done=1, -> FETCH.
- JMP: pcwr=1, instr_done=1, -> FETCH.
  - npc_sel=10 for j/jal, 11 for jr.
  - jal additionally: gprwr=1, RegDst=10, MemToReg=10.
- Latency in cycles with FETCH_WAIT=0: beq/j/jal/jr 3; R/ori/lui/addi/sw 4; lw 5.
- Undefined op/funct: DCD -> FETCH, no writes, no instr_done (NOP).
- rst asserted in any state: next cycle IDLE, outputs 0 in that cycle. No partial write can occur after the reset edge.
- gprwr and dmwr are never both 1. pcwr=1 only in FETCH, BR or JMP.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - adds output illegal (1 bit), reset 0.
  - Undefined op/funct in DCD sets illegal sticky and moves to HALT.
  - HALT holds all other outputs 0 until rst.
- Undefined: the illegal port is absent; undefined instructions behave as NOP as above.

Test Plan:
- Reset then addu (op=0, funct=100001): IDLE, FETCH(pcwr=irwr=1), DCD, EXE(ALUOp=000), WB(gprwr=1, RegDst=01, MemToReg=00, instr_done=1); next FETCH on cycle 5.
- addi (op=001000) with overflow=1 in WB -> gprwr=1, write_30=1, RegDst=00. Repeat with overflow=0 -> write_30=0.
- lw (op=100011): WB in LWB on 5th cycle, gprwr=1, MemToReg=01. sw (op=101011): dmwr=1 in MW, gprwr=0 throughout.
- beq: zero=1 -> BR pcwr=1, npc_sel=01. zero=0 -> pcwr=0. Both return to FETCH after 3 cycles.
- jal (op=000011): JMP pcwr=1, npc_sel=10, gprwr=1, RegDst=10, MemToReg=10. jr (funct=001000): npc_sel=11, gprwr=0.
- FETCH_WAIT=2: pcwr/irwr only on 3rd FETCH cycle. rst=1 asserted during EXE -> IDLE next cycle, gprwr never pulses. Undefined op=111111 with MC_CTRL_ILLEGAL_TRAP_EN -> illegal=1, HALT.
